// File: rtl/fp_issue_ctrl_if.sv
// Bundles the ID-stage FP instruction, the FPU in-flight status and the
// issue/interlock results exchanged between the decoder and fp_issue_ctrl.
interface fp_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_fp;
    logic [2:0]       id_fop;
    logic             id_fwr;
    logic [4:0]       id_fd;
    logic [4:0]       id_fs;
    logic [4:0]       id_ft;
    logic             id_use_fs;
    logic             id_use_ft;
    logic             no_cache_stall;
    logic [4:0]       e1n;
    logic [4:0]       e2n;
    logic [4:0]       e3n;
    logic [4:0]       wn;
    logic             e1w;
    logic             e2w;
    logic             e3w;
    logic             ww;
    logic [2:0]       fc;
    logic             wf;
    logic [4:0]       fd;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             stall_fp;
    logic             st_ds;
    logic             ein1;
    logic             ein2;
    logic [4:0]       div_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_fp, id_fop, id_fwr, id_fd, id_fs, id_ft, id_use_fs, id_use_ft,
        output no_cache_stall, e1n, e2n, e3n, wn, e1w, e2w, e3w, ww,
        input  fc, wf, fd, fwda, fwdb, stall_fp, st_ds, ein1, ein2, div_cnt, stall_cnt
    );

    modport slave (
        input  id_fp, id_fop, id_fwr, id_fd, id_fs, id_ft, id_use_fs, id_use_ft,
        input  no_cache_stall, e1n, e2n, e3n, wn, e1w, e2w, e3w, ww,
        output fc, wf, fd, fwda, fwdb, stall_fp, st_ds, ein1, ein2, div_cnt, stall_cnt
    );
endinterface

// File: rtl/fp_issue_ctrl.sv
// ID-stage issue/interlock controller for the E1-E2-E3-W FPU: operand forwarding,
// RAW and divide-unit stalls, and the fdiv/fsqrt busy countdown.
module fp_issue_ctrl #(
    parameter logic [4:0] DIV_LAT  = 5'd14,
    parameter logic [4:0] SQRT_LAT = 5'd20,
    parameter int         CNT_W    = 16
) (
    input  logic          clk,
    input  logic          clrn,
    fp_issue_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [2:0] fwd_a_s;
    logic [2:0] fwd_b_s;
    logic       st_ds_s;
    logic       stall_fp_s;

    // Returns {raw, sel[1:0]}; E1/E2 results are not yet available, so they interlock.
    function automatic logic [2:0] fwd_sel(
        input logic       use_src,
        input logic [4:0] src,
        input logic [4:0] n1, input logic w1,
        input logic [4:0] n2, input logic w2,
        input logic [4:0] n3, input logic w3,
        input logic [4:0] nw, input logic w4
    );
        logic [2:0] res;
        res = 3'b000;
        if (!use_src) begin
            res = 3'b000;
        end else if (w1 && (n1 == src)) begin
            res = 3'b100;
        end else if (w2 && (n2 == src)) begin
            res = 3'b100;
        end else if (w3 && (n3 == src)) begin
            res = 3'b001;
        end else if (w4 && (nw == src)) begin
            res = 3'b010;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Forwarding selects, stall and FPU issue signals.
    always_comb begin
        fwd_a_s    = fwd_sel(bus.id_use_fs & bus.id_fp, bus.id_fs,
                             bus.e1n, bus.e1w, bus.e2n, bus.e2w,
                             bus.e3n, bus.e3w, bus.wn, bus.ww);
        fwd_b_s    = fwd_sel(bus.id_use_ft & bus.id_fp, bus.id_ft,
                             bus.e1n, bus.e1w, bus.e2n, bus.e2w,
                             bus.e3n, bus.e3w, bus.wn, bus.ww);
        st_ds_s    = (state_q == BUSY);
        stall_fp_s = bus.id_fp & (fwd_a_s[2] | fwd_b_s[2] | st_ds_s |
                                  ((state_q != IDLE) & bus.id_fop[2]));
    end

    assign bus.fc        = bus.id_fop;
    assign bus.fd        = bus.id_fd;
    assign bus.wf        = bus.id_fp & bus.id_fwr & ~stall_fp_s;
    assign bus.fwda      = fwd_a_s[1:0];
    assign bus.fwdb      = fwd_b_s[1:0];
    assign bus.stall_fp  = stall_fp_s;
    assign bus.st_ds     = st_ds_s;
    assign bus.ein1      = bus.no_cache_stall;
    assign bus.ein2      = ~stall_fp_s;
    assign bus.div_cnt   = div_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;

    // Divide-unit FSM and stall counter next state; a cache stall freezes the FSM only.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.no_cache_stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.id_fp && bus.id_fop[2] && !stall_fp_s) begin
                        state_d   = BUSY;
                        div_cnt_d = bus.id_fop[1] ? (SQRT_LAT - 5'd1) : (DIV_LAT - 5'd1);
                    end else begin
                        state_d   = IDLE;
                    end
                end
                BUSY: begin
                    if (div_cnt_q == 5'd1) begin
                        state_d   = IDLE;
                        div_cnt_d = 5'd0;
                    end else begin
                        div_cnt_d = div_cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    div_cnt_d = 5'd0;
                end
            endcase
        end else begin
            state_d   = state_q;
            div_cnt_d = div_cnt_q;
        end
        if (stall_fp_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q     <= IDLE;
            div_cnt_q   <= 5'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
